// File: rtl/invtlb_walk_ctrl.sv
// INVTLB sequencer: walks every TLB entry, pulses per-entry clears and arbitrates the TLB write port.
// Latency: done at start+TLBNUM+1; start+1 for op>6; start+2 for ops 0/1 when INVTLB_FASTCLR_EN is defined.
// Backpressure: busy holds WB for the whole walk; WB writes are granted only while idle.
module invtlb_walk_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inv_start,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [31:0]      inv_va,
    output logic [IDX_W-1:0] r_index,
    input  logic             r_e,
    input  logic             r_g,
    input  logic [9:0]       r_asid,
    input  logic [18:0]      r_vppn,
    input  logic [5:0]       r_ps,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_index,
    output logic             clr_all,
    input  logic             wb_w_req,
    input  logic [IDX_W-1:0] wb_w_index,
    output logic             w_gnt,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output logic             busy,
    output logic             done,
    output logic             op_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        FIN    = 2'd2,
        CLRALL = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [4:0]       op_q;
    logic [9:0]       asid_q;
    logic [18:0]      vppn_q;
    logic             op_err_q;

    logic asid_hit, vppn_hit, entry_hit;
    logic op_bad, op_fast;

    // The page offset bits of the operand never take part in a match.
    logic unused_va_lo;
    assign unused_va_lo = ^inv_va[12:0];

    assign op_bad = (inv_op > 5'd6);
`ifdef INVTLB_FASTCLR_EN
    assign op_fast = (inv_op <= 5'd1);
`else
    assign op_fast = 1'b0;
    assign clr_all = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            asid_q   <= '0;
            vppn_q   <= '0;
            op_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && inv_start) begin
                op_q     <= inv_op;
                asid_q   <= inv_asid;
                vppn_q   <= inv_va[31:13];
                op_err_q <= op_bad;
                cnt_q    <= '0;
            end else if (state_q == WALK) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // A 4MB page (ps 21) only owns the upper 10 bits of the vppn.
    assign asid_hit = (r_asid == asid_q);
    assign vppn_hit = (r_ps == 6'd21) ? (r_vppn[18:9] == vppn_q[18:9]) : (r_vppn == vppn_q);

    always_comb begin
        entry_hit = 1'b0;
        case (op_q)
            5'd0, 5'd1: entry_hit = 1'b1;
            5'd2:       entry_hit = r_g;
            5'd3:       entry_hit = !r_g;
            5'd4:       entry_hit = !r_g && asid_hit;
            5'd5:       entry_hit = !r_g && asid_hit && vppn_hit;
            5'd6:       entry_hit = (r_g || asid_hit) && vppn_hit;
            default:    entry_hit = 1'b0;
        endcase
    end

    assign r_index   = cnt_q;
    assign clr_index = cnt_q;

    always_comb begin
        state_d     = state_q;
        clr_we      = 1'b0;
`ifdef INVTLB_FASTCLR_EN
        clr_all     = 1'b0;
`endif
        busy        = 1'b0;
        done        = 1'b0;
        op_err      = 1'b0;
        w_gnt       = 1'b0;
        tlb_we      = 1'b0;
        tlb_w_index = '0;
        case (state_q)
            IDLE: begin
                // A WB write in the same cycle as a start still goes through; the walk begins next cycle.
                w_gnt       = wb_w_req;
                tlb_we      = wb_w_req;
                tlb_w_index = wb_w_index;
                if (inv_start) begin
                    if (op_bad)       state_d = FIN;
                    else if (op_fast) state_d = CLRALL;
                    else              state_d = WALK;
                end
            end
            WALK: begin
                busy   = 1'b1;
                clr_we = entry_hit && r_e;
                if (cnt_q == IDX_W'(TLBNUM - 1)) state_d = FIN;
            end
`ifdef INVTLB_FASTCLR_EN
            CLRALL: begin
                busy    = 1'b1;
                clr_we  = 1'b1;
                clr_all = 1'b1;
                state_d = FIN;
            end
`endif
            FIN: begin
                done    = 1'b1;
                op_err  = op_err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_invtlb_walk_ctrl.sv
// Scoreboard bench for invtlb_walk_ctrl: a TLB array model feeds the read port, expected events are queued at issue.
module tb_invtlb_walk_ctrl;

    localparam int N = 16;

    typedef struct packed {
        logic        e;
        logic        g;
        logic [9:0]  asid;
        logic [18:0] vppn;
        logic [5:0]  ps;
    } ent_t;

    typedef struct {
        int kind;   // 0 clear, 1 done, 2 write grant
        int cyc;
        int idx;
        bit flag;
    } ev_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inv_start = 1'b0;
    logic [4:0]  inv_op = '0;
    logic [9:0]  inv_asid = '0;
    logic [31:0] inv_va = '0;
    logic [3:0]  r_index;
    logic        r_e, r_g;
    logic [9:0]  r_asid;
    logic [18:0] r_vppn;
    logic [5:0]  r_ps;
    logic        clr_we, clr_all;
    logic [3:0]  clr_index;
    logic        wb_w_req = 1'b0;
    logic [3:0]  wb_w_index = '0;
    logic        w_gnt, tlb_we;
    logic [3:0]  tlb_w_index;
    logic        busy, done, op_err;

    ent_t tlb [N];
    ev_t  exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;

    invtlb_walk_ctrl #(.TLBNUM(N), .IDX_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .inv_start(inv_start), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn), .r_ps(r_ps),
        .clr_we(clr_we), .clr_index(clr_index), .clr_all(clr_all),
        .wb_w_req(wb_w_req), .wb_w_index(wb_w_index), .w_gnt(w_gnt),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
        .busy(busy), .done(done), .op_err(op_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign r_e    = tlb[r_index].e;
    assign r_g    = tlb[r_index].g;
    assign r_asid = tlb[r_index].asid;
    assign r_vppn = tlb[r_index].vppn;
    assign r_ps   = tlb[r_index].ps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen at cycle %0d, none expected (next expected cycle %0d)",
                 name, cyc, (exp_q.size() > 0) ? exp_q[0].cyc : -1);
    endtask

    // Which entries INVTLB removes, straight from the op table.
    function automatic bit model_hit(input int op, input logic [9:0] asid, input logic [18:0] vppn, input ent_t x);
        bit same_asid, same_page;
        same_asid = (x.asid == asid);
        same_page = (x.ps == 6'd21) ? ((x.vppn >> 9) == (vppn >> 9)) : (x.vppn == vppn);
        case (op)
            0, 1:    return 1'b1;
            2:       return x.g;
            3:       return !x.g;
            4:       return !x.g && same_asid;
            5:       return !x.g && same_asid && same_page;
            6:       return (x.g || same_asid) && same_page;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push(input int kind, input int c, input int idx, input bit flag);
        ev_t ev;
        ev.kind = kind; ev.cyc = c; ev.idx = idx; ev.flag = flag;
        exp_q.push_back(ev);
    endfunction

    // Monitor: compare whatever the DUT presents this cycle, then apply it to the TLB model.
    always @(negedge clk) begin
        ev_t ev;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            ev = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event kind %0d idx %0d: expected at cycle %0d, not seen", ev.kind, ev.idx, ev.cyc);
        end
        check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
        check("clr_and_write_overlap", clr_we & tlb_we, 0);
        check("tlb_we_vs_gnt", tlb_we, w_gnt);
        if (clr_we) begin
            if (exp_q.size() == 0 || exp_q[0].kind != 0 || exp_q[0].cyc != cyc) unexpected("clr_we");
            else begin
                ev = exp_q.pop_front();
                check("clr_all", clr_all, ev.flag);
                if (!ev.flag) check("clr_index", clr_index, ev.idx);
            end
        end else check("clr_all_quiet", clr_all, 0);
        if (done) begin
            if (exp_q.size() == 0 || exp_q[0].kind != 1 || exp_q[0].cyc != cyc) unexpected("done");
            else begin
                ev = exp_q.pop_front();
                check("op_err", op_err, ev.flag);
            end
        end else check("op_err_quiet", op_err, 0);
        if (w_gnt) begin
            if (exp_q.size() == 0 || exp_q[0].kind != 2 || exp_q[0].cyc != cyc) unexpected("w_gnt");
            else begin
                ev = exp_q.pop_front();
                check("tlb_w_index", tlb_w_index, ev.idx);
            end
        end
        if (clr_we) begin
            if (clr_all) for (int i = 0; i < N; i++) tlb[i].e = 1'b0;
            else tlb[clr_index].e = 1'b0;
        end
        if (tlb_we) tlb[tlb_w_index].e = 1'b1;
    end

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            tlb[i].e    = ($urandom % 4) != 0;
            tlb[i].g    = ($urandom % 4) == 0;
            tlb[i].asid = 10'($urandom % 4);
            tlb[i].vppn = 19'((($urandom % 4) << 9) | ($urandom % 4));
            tlb[i].ps   = ($urandom % 2) ? 6'd21 : 6'd12;
        end
    endtask

    // Issue one INVTLB at the current cycle (called at posedge+1 while idle) and queue its expected events.
    task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [31:0] va,
                           input bit wreq_now, input bit wreq_hold, input logic [3:0] widx, input bit fin_poke);
        int   t, done_c;
        ent_t snap [N];
        bit   fast;
        t = cyc;
        inv_start = 1'b1; inv_op = op; inv_asid = asid; inv_va = va;
        wb_w_req = wreq_now | wreq_hold; wb_w_index = widx;
        snap = tlb;
        if (wreq_now | wreq_hold) begin
            snap[widx].e = 1'b1;
            push(2, t, widx, 1'b0);
        end
        fast = 1'b0;
`ifdef INVTLB_FASTCLR_EN
        fast = (op <= 5'd1);
`endif
        if (op > 5'd6) done_c = t + 1;
        else if (fast) begin
            push(0, t + 1, 0, 1'b1);
            done_c = t + 2;
        end else begin
            for (int i = 0; i < N; i++)
                if (snap[i].e && model_hit(int'(op), asid, va[31:13], snap[i])) push(0, t + 1 + i, i, 1'b0);
            done_c = t + N + 1;
        end
        busy_lo = t + 1;
        busy_hi = done_c - 1;
        push(1, done_c, 0, op > 5'd6);
        if (wreq_hold) push(2, done_c + 1, widx, 1'b0);
        @(posedge clk); #1;
        wb_w_req = wreq_hold;
        inv_op = 5'd3;
        inv_va = $urandom;
        while (cyc < done_c + 2) begin
            inv_start = fin_poke && (cyc == done_c);
            @(posedge clk); #1;
        end
        inv_start = 1'b0;
        wb_w_req = 1'b0;
    endtask

    initial begin
        int t;
        logic [4:0] op;
        logic [3:0] idx;
        for (int i = 0; i < N; i++) tlb[i] = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clr_we", clr_we, 0);
        check("rst_w_gnt", w_gnt, 0);
        check("rst_tlb_we", tlb_we, 0);
        check("rst_op_err", op_err, 0);
        check("rst_r_index", r_index, 0);
        check("rst_clr_all", clr_all, 0);
        @(posedge clk); #1;

        // op 2: only the global entries 3 and 9 go
        for (int i = 0; i < N; i++) begin
            tlb[i] = '0; tlb[i].e = 1'b1; tlb[i].ps = 6'd12; tlb[i].g = (i == 3 || i == 9);
        end
        run_inv(5'd2, 10'h0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1);

        // op 5: the 4KB and 4MB non-global matches go, the global one stays
        for (int i = 0; i < N; i++) tlb[i] = '0;
        tlb[4] = '{e: 1'b1, g: 1'b0, asid: 10'h005, vppn: 19'h00201, ps: 6'd12};
        tlb[7] = '{e: 1'b1, g: 1'b0, asid: 10'h005, vppn: 19'h00200, ps: 6'd21};
        tlb[8] = '{e: 1'b1, g: 1'b1, asid: 10'h005, vppn: 19'h00201, ps: 6'd12};
        run_inv(5'd5, 10'h005, 32'h0040_2000, 1'b0, 1'b0, 4'd0, 1'b0);
        check("op5_keeps_global", tlb[8].e, 1);

        // op 7: no walk, done and op_err together one cycle later
        fill_random();
        run_inv(5'd7, 10'h1, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1);

        // WB write held through a walk is granted only once idle again
        fill_random();
        run_inv(5'd3, 10'h0, 32'h0, 1'b0, 1'b1, 4'd6, 1'b0);

        // op 0 together with a write: the freshly written entry is also cleared
        for (int i = 0; i < N; i++) begin
            tlb[i] = '0; tlb[i].e = (i != 11); tlb[i].ps = 6'd12;
        end
        run_inv(5'd0, 10'h0, 32'h0, 1'b1, 1'b0, 4'd11, 1'b0);

        // reset in the middle of an op-3 walk
        for (int i = 0; i < N; i++) begin
            tlb[i] = '0; tlb[i].e = 1'b1; tlb[i].ps = 6'd12;
        end
        t = cyc;
        inv_start = 1'b1; inv_op = 5'd3;
        for (int i = 0; i < 5; i++) push(0, t + 1 + i, i, 1'b0);
        busy_lo = t + 1;
        busy_hi = t + 5;
        @(posedge clk); #1;
        inv_start = 1'b0;
        while (cyc < t + 6) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        check("midwalk_rst_busy", busy, 0);
        check("midwalk_rst_clr_we", clr_we, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1;
        wb_w_req = 1'b1; wb_w_index = 4'd6;
        push(2, cyc, 6, 1'b0);
        @(posedge clk); #1;
        wb_w_req = 1'b0;

        // randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            fill_random();
            op = 5'($urandom % 9);
            if (op == 5'd8) op = 5'(7 + ($urandom % 25));
            idx = 4'($urandom % N);
            run_inv(op, 10'($urandom % 4),
                    {13'((($urandom % 4) << 9) | ($urandom % 4)), 6'd0, 13'($urandom)},
                    ($urandom % 4) == 0, ($urandom % 4) == 0, 4'($urandom % N), ($urandom % 2) == 1);
            if ($urandom % 2) begin
                wb_w_req = 1'b1; wb_w_index = idx;
                push(2, cyc, idx, 1'b0);
                @(posedge clk); #1;
                wb_w_req = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/invtlb_walk_ctrl.md
Name: invtlb_walk_ctrl

Overview:
- Multi-cycle sequencer for INVTLB, driven from the WB stage; owns the TLB read port and the TLB invalidate/write port while active.
- Walks all TLB entries, evaluates the op-specific match, and issues per-entry clear pulses.
- Arbitrates the TLB write port between the walker and WB tlbwr/tlbfill writes.
- Holds WB (busy) until the walk completes, then pulses done, which WB uses to raise its refetch flush.

Parameters:
- TLBNUM, 16, number of TLB entries (power of 2).
- IDX_W, 4, index width, log2(TLBNUM).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- inv_start  in  1  WB invtlb valid (inst_invtlb & valid); sampled only in IDLE
- inv_op  in  5  invtlb op field
- inv_asid  in  10  rj[9:0] asid operand
- inv_va  in  32  rk virtual address operand
- r_index  out  IDX_W  TLB read index (combinational read port)
- r_e, r_g  in  1 each  entry valid / global
- r_asid  in  10  entry asid
- r_vppn  in  19  entry vppn
- r_ps  in  6  entry page size (12 or 21)
- clr_we  out  1  invalidate pulse: clear E of entry clr_index
- clr_index  out  IDX_W  entry to clear
- wb_w_req  in  1  WB tlbwr|tlbfill write request
- wb_w_index  in  IDX_W  WB write index
- w_gnt  out  1  WB write granted this cycle
- tlb_we  out  1  TLB write enable to TLB
- tlb_w_index  out  IDX_W  TLB write index
- busy  out  1  walk in progress; WB must hold (readygo low)
- done  out  1  one-cycle pulse, walk finished
- op_err  out  1  one-cycle pulse with done when op > 6

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0.
- States: IDLE, WALK, FIN.
- IDLE: inv_start=1 latches op/asid/vppn=inv_va[31:13]; counter<=0; op>6 goes to FIN with op_err latched, else goes to WALK. busy=1 from the cycle after start.
- WALK: r_index=counter. clr_we=match & r_e, clr_index=counter, same cycle. Counter increments each cycle; at counter==TLBNUM-1 goes to FIN. Walk length is exactly TLBNUM cycles.
- Match by op:
  - 0, 1: all entries.
  - 2: G=1.
  - 3: G=0.
  - 4: G=0 & asid==r_asid.
  - 5: G=0 & asid match & vppn match.
  - 6: (G=1 | asid match) & vppn match.
- vppn match: r_ps==21 compares [18:9] only; otherwise compares all 19 bits.
- FIN: done=1 (and op_err if latched) for one cycle, busy=0, return to IDLE. inv_start in the FIN cycle is ignored; WB does not re-assert start for the same instruction because done releases it.
- Latency: start at cycle t, done at t+TLBNUM+1 for valid ops, t+1 for op>6.
- Write arbitration: walker has priority.
  - busy=1: w_gnt=0, tlb_we=0, wb_w_req held off.
  - IDLE: w_gnt=wb_w_req, tlb_we=wb_w_req, tlb_w_index=wb_w_index, same cycle.
  - Simultaneous inv_start and wb_w_req in IDLE: write granted that cycle, walk starts next cycle.
  - clr_we and tlb_we are never asserted in the same cycle.
- Entries with r_e=0 produce no clr_we.
- Reset mid-walk: immediate return to IDLE, no further clr_we, no done.

Optional Feature:
- INVTLB_FASTCLR_EN defined: ops 0/1 skip WALK.
  - In the start-acceptance cycle's successor, a single clr_we with a new output clr_all=1 clears every entry.
  - Then FIN; done at t+2.
- Undefined: ops 0/1 walk like other ops, and clr_all is tied to 0.

Test Plan:
- Reset mid-walk: start op 3, assert resetn=0 at walk cycle 5 -> busy=0 and clr_we=0 immediately, done never pulses; after release, IDLE grants wb_w_req at once.
- Op 2: entries 3 and 9 have G=1, all E=1 -> clr_we only at clr_index 3 and 9; busy for 16 cycles; done at t+17.
- Op 5 with asid=0x05, va=0x0040_2000:
  - entry 4 (G=0, asid 5, vppn 0x00201, ps 12) is cleared.
  - entry 7 (same, ps 21, vppn 0x00200) is cleared via the 4MB compare.
  - entry 8 (G=1) is not cleared.
- Op 7 -> no clr_we, done and op_err pulse at t+1.
- Arbitration: wb_w_req=1, index 6 during WALK -> w_gnt=0, tlb_we=0 until done. Next cycle in IDLE -> tlb_we=1, tlb_w_index=6.
- Simultaneous start (op 0) and wb_w_req in IDLE -> write granted in cycle t; walk clears all 16 valid entries in cycles t+1..t+16. With INVTLB_FASTCLR_EN -> single clr_all pulse at t+1, done at t+2.
